// File: rtl/dma_mem_pkg.sv
// Shared types and limits for the DMA memory model.
package dma_mem_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int MAX_RD_LAT = 8;

endpackage

// File: rtl/rd_delay_line.sv
// Valid+data shift register: DEPTH cycles latency, no backpressure (always shifts).
// Valid bits are reset so in-flight entries vanish on reset; data bits are not.
module rd_delay_line #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= i_vld;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        dat_q[0] <= i_dat;
        for (int i = 1; i < DEPTH; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign o_vld = vld_q[DEPTH-1];
    assign o_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/dma_mem_model.sv
// DMA-port memory model: init sweep after reset, write-first reads returned RD_LAT cycles after accept.
// Backpressure: o_rd_ready drops one cycle in every STALL_PERIOD; requests seen while low are dropped.
module dma_mem_model
    import dma_mem_pkg::*;
#(
    parameter int            DW           = 16,
    parameter int            AW           = 10,
    parameter int            RD_LAT       = 2,
    parameter int            STALL_PERIOD = 0,
    parameter int            INIT_EN      = 1,
    parameter logic [DW-1:0] INIT_VAL     = DW'(16'h0101)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    output logic          o_rd_ready,
    output logic          o_wr_ready,
    output logic          o_init_done
);

    localparam int DEPTH = 1 << AW;
    localparam int LAT   = (RD_LAT < 1) ? 1 : ((RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT);
    localparam int SCW   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SCW-1:0] STALL_LAST = SCW'((STALL_PERIOD > 1) ? STALL_PERIOD - 1 : 0);

    state_t          state_q, state_d;
    logic [AW:0]     init_cnt_q, init_cnt_d;
    logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
    logic [DW-1:0]   rd_hold_q, rd_hold_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic            run, sweep, stall_now;
    logic            mem_we, rd_accept, pipe_vld;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata, rd_word, pipe_dat;

    assign run = (state_q == ST_RUN);

    // The sweep starts in the first cycle after reset release so that RUN begins
    // exactly 2**AW cycles later; the extra counter bit flags the wrap.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        stall_cnt_d = stall_cnt_q;
        sweep       = 1'b0;
        case (state_q)
            ST_RESET, ST_INIT: begin
                if (INIT_EN != 0) begin
                    sweep      = 1'b1;
                    init_cnt_d = init_cnt_q + 1'b1;
                    state_d    = init_cnt_d[AW] ? ST_RUN : ST_INIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (STALL_PERIOD > 1) begin
                    stall_cnt_d = (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign stall_now = (STALL_PERIOD > 1) && (stall_cnt_q == STALL_LAST);
    assign mem_we    = sweep | (run & i_wr_en);
    assign mem_waddr = sweep ? init_cnt_q[AW-1:0] : i_wr_addr;
    assign mem_wdata = sweep ? INIT_VAL : i_wr_data;
    assign rd_accept = i_rd_en & o_rd_ready;
    // Write-first: a same-cycle write to the read address is forwarded.
    assign rd_word   = (mem_we && (mem_waddr == i_rd_addr)) ? mem_wdata : mem_q[i_rd_addr];

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    rd_delay_line #(
        .W     (DW),
        .DEPTH (LAT)
    ) u_rd_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_vld (rd_accept),
        .i_dat (rd_word),
        .o_vld (pipe_vld),
        .o_dat (pipe_dat)
    );

    assign rd_hold_d = pipe_vld ? pipe_dat : rd_hold_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_RESET;
            init_cnt_q  <= '0;
            stall_cnt_q <= '0;
            rd_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    assign o_rd_data   = rd_hold_d;
    assign o_rd_valid  = pipe_vld;
    assign o_rd_ready  = run & ~stall_now;
    assign o_wr_ready  = run;
    assign o_init_done = run;

endmodule

// File: tb/tb_dma_mem_model.sv
// Scoreboard bench: three model configurations (base, RD_LAT=4 no-init, STALL_PERIOD=3),
// exercised one at a time; returned reads are matched against a queue of expected words.
module tb_dma_mem_model;

    typedef struct packed {
        logic [1:0]  inst;
        logic [15:0] dat;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en   [3];
    logic [3:0]  wr_addr [3];
    logic [15:0] wr_data [3];
    logic        rd_en   [3];
    logic [3:0]  rd_addr [3];
    logic [15:0] rd_data [3];
    logic        rd_vld  [3];
    logic        rd_rdy  [3];
    logic        wr_rdy  [3];
    logic        done    [3];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_mem_model #(.DW(16), .AW(4), .RD_LAT(2), .STALL_PERIOD(0), .INIT_EN(1), .INIT_VAL(16'h0101)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]), .i_wr_data(wr_data[0]),
        .i_rd_en(rd_en[0]), .i_rd_addr(rd_addr[0]),
        .o_rd_data(rd_data[0]), .o_rd_valid(rd_vld[0]), .o_rd_ready(rd_rdy[0]),
        .o_wr_ready(wr_rdy[0]), .o_init_done(done[0]));

    dma_mem_model #(.DW(16), .AW(4), .RD_LAT(4), .STALL_PERIOD(0), .INIT_EN(0), .INIT_VAL(16'h0101)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]), .i_wr_data(wr_data[1]),
        .i_rd_en(rd_en[1]), .i_rd_addr(rd_addr[1]),
        .o_rd_data(rd_data[1]), .o_rd_valid(rd_vld[1]), .o_rd_ready(rd_rdy[1]),
        .o_wr_ready(wr_rdy[1]), .o_init_done(done[1]));

    dma_mem_model #(.DW(16), .AW(4), .RD_LAT(2), .STALL_PERIOD(3), .INIT_EN(1), .INIT_VAL(16'h0101)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(wr_en[2]), .i_wr_addr(wr_addr[2]), .i_wr_data(wr_data[2]),
        .i_rd_en(rd_en[2]), .i_rd_addr(rd_addr[2]),
        .o_rd_data(rd_data[2]), .o_rd_valid(rd_vld[2]), .o_rd_ready(rd_rdy[2]),
        .o_wr_ready(wr_rdy[2]), .o_init_done(done[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 1) ? 4 : 2;
    endfunction

    // Drive one cycle of requests on instance i; reads are assumed accepted.
    task automatic issue(input int i, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic re, input logic [3:0] ra, input logic [15:0] ed);
        wr_en[i]   = we;
        wr_addr[i] = wa;
        wr_data[i] = wd;
        rd_en[i]   = re;
        rd_addr[i] = ra;
        if (re) exp_q.push_back('{inst: 2'(i), dat: ed, due: cyc + lat_of(i)});
        @(negedge clk);
        wr_en[i] = 1'b0;
        rd_en[i] = 1'b0;
    endtask

    task automatic wait_init(output int k);
        k = 0;
        for (int t = 1; t <= 40 && done[0] !== 1'b1; t++) begin
            @(negedge clk);
            k = t;
            if (t == 1) begin
                chk("noinit_done", done[1], 1);
                chk("noinit_rd_rdy", rd_rdy[1], 1);
                chk("noinit_wr_rdy", wr_rdy[1], 1);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rd_vld[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_vld%0d", i), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_inst", i, e.inst);
                    chk("rd_data", rd_data[i], e.dat);
                    chk("rd_lat", cyc, e.due);
                end
            end
        end
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            chk("rd_missing", cyc, e.due);
        end
    end

    initial begin
        int k;
        int run0;
        int acc;
        logic mr;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
            rd_en[i] = 1'b0; rd_addr[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_rd_data", rd_data[0], 0);
        chk("rst_rd_vld", rd_vld[0], 0);
        chk("rst_rd_rdy", rd_rdy[0], 0);
        chk("rst_wr_rdy", wr_rdy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_done1", done[1], 0);

        rst = 1'b0;
        wait_init(k);
        chk("init_latency", k, 16);
        chk("init_rd_rdy", rd_rdy[0], 1);
        chk("init_wr_rdy", wr_rdy[0], 1);
        chk("init_done2", done[2], 1);
        chk("init_wr_rdy2", wr_rdy[2], 1);
        run0 = cyc;

        for (int a = 0; a < 16; a++) issue(0, 1'b0, 4'd0, 16'd0, 1'b1, 4'(a), 16'h0101);
        issue(0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'd0);
        issue(0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'hBEEF);
        issue(0, 1'b1, 4'd3, 16'h1234, 1'b1, 4'd3, 16'h1234);
        issue(0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1234);
        issue(0, 1'b1, 4'd3, 16'hAAAA, 1'b0, 4'd0, 16'd0);
        issue(0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'hAAAA);
        repeat (5) @(negedge clk);
        chk("drain0", exp_q.size(), 0);
        chk("rd_hold", rd_data[0], 16'hAAAA);

        for (int a = 0; a < 8; a++) issue(1, 1'b1, 4'(a), 16'(16'h1000 + a * 16'h11), 1'b0, 4'd0, 16'd0);
        for (int a = 0; a < 8; a++) issue(1, 1'b0, 4'd0, 16'd0, 1'b1, 4'(a), 16'(16'h1000 + a * 16'h11));
        repeat (6) @(negedge clk);
        chk("drain1", exp_q.size(), 0);

        for (int a = 0; a < 8; a++) issue(2, 1'b1, 4'(a), 16'(16'h2000 + a), 1'b0, 4'd0, 16'd0);
        acc = 0;
        for (int t = 0; t < 12; t++) begin
            mr = (((cyc - run0) % 3) != 2);
            chk("stall_rdy", rd_rdy[2], mr);
            rd_en[2]   = 1'b1;
            rd_addr[2] = acc[3:0];
            if (mr) begin
                exp_q.push_back('{inst: 2'd2, dat: 16'(16'h2000 + acc), due: cyc + 2});
                acc++;
            end
            @(negedge clk);
        end
        rd_en[2] = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain2", exp_q.size(), 0);

        issue(1, 1'b0, 4'd0, 16'd0, 1'b1, 4'd2, 16'h1022);
        issue(1, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1033);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_rd_data", rd_data[1], 0);
        chk("midrst_rd_vld", rd_vld[1], 0);
        chk("midrst_rd_rdy", rd_rdy[1], 0);
        chk("midrst_done", done[1], 0);
        chk("midrst_done0", done[0], 0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        wait_init(k);
        chk("reinit_latency", k, 16);
        issue(0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'h0101);
        issue(0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h0101);
        issue(0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h0101);
        issue(0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd15, 16'h0101);
        repeat (5) @(negedge clk);
        chk("drain_final", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_mem_model.md
# dma_mem_model

Parametrised memory model behind the accelerator's DMA port, replacing the fixed zero-latency constant-data memory on the bench. It provides write storage, a fixed-latency pipelined read return with valid strobe, a deterministic back-pressure pattern on the read-ready line, and a post-reset initialisation sweep. It connects directly to `nn`'s `o_dma_*` outputs and `i_dma_rd_data`/`i_dma_rd_ready` inputs.

## Interface
- `DW`, 16, data width
- `AW`, 10, address width; depth = 2**AW words
- `RD_LAT`, 2, read latency in cycles, legal 1..8
- `STALL_PERIOD`, 0, ready drops one cycle in every STALL_PERIOD; 0 = never, 1 illegal
- `INIT_EN`, 1, 1 = sweep-write INIT_VAL to every address after reset
- `INIT_VAL`, 16'h0101, init word (DW bits)

- `i_clk` in 1 — single clock, rising edge
- `i_rst` in 1 — asynchronous, active-high reset
- `i_wr_en` in 1 — write request
- `i_wr_addr` in AW — write address
- `i_wr_data` in DW — write data
- `i_rd_en` in 1 — read request
- `i_rd_addr` in AW — read address
- `o_rd_data` out DW — read return data
- `o_rd_valid` out 1 — o_rd_data valid this cycle
- `o_rd_ready` out 1 — read request accepted when high with i_rd_en
- `o_wr_ready` out 1 — write accepted when high with i_wr_en
- `o_init_done` out 1 — high once init sweep completes (or immediately after reset if INIT_EN=0)

## Operation
- States: RESET (while i_rst) → INIT (INIT_EN=1) → RUN; INIT_EN=0 goes RESET → RUN.
- INIT: address counter 0..2**AW-1, one word per cycle; o_rd_ready=o_wr_ready=0; external requests ignored; after writing the last address → RUN, o_init_done=1.
- RUN: o_wr_ready=1 always; a write is accepted on every cycle with i_wr_en.
- Read accept: i_rd_en & o_rd_ready. Address sampled that cycle; data word taken from the array *after* any same-cycle write (write-first bypass when i_wr_addr==i_rd_addr).
- Return: accepted read appears on o_rd_data with o_rd_valid=1 exactly RD_LAT cycles after acceptance edge; one read in flight per cycle, up to RD_LAT outstanding; no reordering.
- o_rd_data holds last returned value when o_rd_valid=0.
- Writes issued after a read's acceptance do not affect that read's returned data.
- Stall: free-running counter mod STALL_PERIOD in RUN, cleared on entering RUN; o_rd_ready=0 when counter==STALL_PERIOD-1, else 1. Requests during stall are dropped (requester must hold).
- Address width rule: addresses are AW bits, no out-of-range case; init counter is AW+1 bits to detect wrap.

## Timing
- Reset values: o_rd_data=0, o_rd_valid=0, o_rd_ready=0, o_wr_ready=0, o_init_done=0; delay line, stall counter, init counter cleared. Array contents not reset.
- INIT_EN=1: first RUN cycle is 2**AW cycles after reset release; o_init_done, o_rd_ready, o_wr_ready rise together.
- INIT_EN=0: outputs rise on the first clock edge after reset release.
- Reset mid-operation: in-flight reads discarded (no valid pulse), init restarts from address 0.
- Simultaneous read and write, same address, RUN: read returns new data.
- STALL_PERIOD=2: ready alternates 1,0,1,0 starting with 1 on first RUN cycle.

## Structure
- Package `dma_mem_pkg`: state enum {ST_RESET, ST_INIT, ST_RUN}, max RD_LAT constant (8).
- Sub-module `rd_delay_line`: parametrised (width, depth) valid+data shift register, async-reset valid bits, used for the RD_LAT return pipe.
- Array as synchronous-write register file inside the top.

## Test plan
- INIT_EN=1, AW=4: release reset → o_init_done rises after 16 cycles; reading addr 0..15 returns 16'h0101 each, RD_LAT=2 cycles later.
- Write addr 5=16'hBEEF, then read addr 5 next cycle → o_rd_data=16'hBEEF, o_rd_valid pulse exactly 2 cycles after acceptance.
- Same-cycle write addr 3=16'h1234 and read addr 3 → returns 16'h1234.
- RD_LAT=4, back-to-back reads addr 0..7 every cycle → eight consecutive valid cycles, in order, starting 4 cycles after first accept.
- STALL_PERIOD=3, i_rd_en held high → exactly 2 of every 3 requests accepted; valid pattern 1,1,0 repeating.
- Assert i_rst with 2 reads in flight → no valid pulse appears; all outputs 0 within reset; init restarts at address 0.
